// File: rtl/led_pwm_driver.sv
// led_pwm_driver
//   Drives an LED pin with PWM. A brightness level is latched as a target,
//   then the active duty cycle fades toward it in bounded steps. Duty only
//   changes at a PWM period boundary, so the waveform never glitches.
//
//   Optional build macro: LED_PWM_GAMMA_EN
//     defined   : the target duty comes from a fixed 8-entry gamma table
//                 (LEVEL_W=3, PWM_W=8 only; other widths stop elaboration)
//     undefined : the target duty is the level bit-replicated MSB-first
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   level_in     in   [LEVEL_W] brightness level from the upstream controller
//   level_valid  in   latch level_in as the new target on this clk edge
//   enable       in   output gate; low forces pwm_out low
//   pwm_out      out  registered PWM drive
//   duty_cur     out  [PWM_W] duty active in the current period
//   fading       out  high while duty_cur differs from the target
//   period_start out  one-clk pulse when count 0 first appears on pwm_out
module led_pwm_driver #(
   parameter int LEVEL_W      = 3,
   parameter int PWM_W        = 8,
   parameter int PRESCALE     = 1,
   parameter int FADE_STEP    = 8,
   parameter int FADE_PERIODS = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [LEVEL_W-1:0] level_in,
   input  logic               level_valid,
   input  logic               enable,
   output logic               pwm_out,
   output logic [PWM_W-1:0]   duty_cur,
   output logic               fading,
   output logic               period_start
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FC_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FADE_PERIODS - 1);
   // Last count of the period: 2^PWM_W-2, so a full-scale duty stays high.
   localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};
   localparam logic [PWM_W:0]   STEP     = (PWM_W+1)'(FADE_STEP);

   typedef enum logic [1:0] {FADE_IDLE, FADE_UP, FADE_DOWN} fade_dir_t;

`ifdef LED_PWM_GAMMA_EN
   generate
      if (LEVEL_W != 3 || PWM_W != 8) begin : g_gamma_width_check
         $error("LED_PWM_GAMMA_EN requires LEVEL_W=3 and PWM_W=8");
      end
   endgenerate

   function automatic logic [PWM_W-1:0] map_level(input logic [LEVEL_W-1:0] lvl);
      case (lvl)
         LEVEL_W'(0): map_level = PWM_W'(0);
         LEVEL_W'(1): map_level = PWM_W'(4);
         LEVEL_W'(2): map_level = PWM_W'(11);
         LEVEL_W'(3): map_level = PWM_W'(25);
         LEVEL_W'(4): map_level = PWM_W'(50);
         LEVEL_W'(5): map_level = PWM_W'(90);
         LEVEL_W'(6): map_level = PWM_W'(150);
         default:     map_level = PWM_W'(255);
      endcase
   endfunction
`else
   // Repeat the level bits MSB-first across the duty width so that the
   // all-ones level maps to full scale and zero maps to zero.
   function automatic logic [PWM_W-1:0] map_level(input logic [LEVEL_W-1:0] lvl);
      logic [PWM_W-1:0] m;
      m = '0;
      for (int i = 0; i < PWM_W; i++)
         m[PWM_W-1-i] = lvl[LEVEL_W-1-(i % LEVEL_W)];
      return m;
   endfunction
`endif

   // Step arithmetic is done one bit wider so neither direction can wrap.
   function automatic logic [PWM_W-1:0] step_up(input logic [PWM_W-1:0] cur,
                                                input logic [PWM_W-1:0] tgt);
      logic [PWM_W:0] sum;
      sum = {1'b0, cur} + STEP;
      return (sum > {1'b0, tgt}) ? tgt : sum[PWM_W-1:0];
   endfunction

   function automatic logic [PWM_W-1:0] step_down(input logic [PWM_W-1:0] cur,
                                                  input logic [PWM_W-1:0] tgt);
      logic [PWM_W:0] floor_v;
      floor_v = {1'b0, tgt} + STEP;
      return ({1'b0, cur} >= floor_v) ? (cur - STEP[PWM_W-1:0]) : tgt;
   endfunction

   logic [PS_W-1:0]    pre_q, pre_d;
   logic [PWM_W-1:0]   cnt_q, cnt_d;
   logic [FC_W-1:0]    fade_cnt_q, fade_cnt_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [PWM_W-1:0]   duty_q, duty_d;
   logic               pwm_q, pwm_d;
   logic               pstart_q, pstart_d;

   logic               tick;
   logic               boundary;
   logic [PWM_W-1:0]   duty_tgt;
   fade_dir_t          fade_dir;

   always_comb begin
      // With PRESCALE=1, PS_LAST is 0 and the prescaler sits at 0, so tick
      // is permanently high.
      tick     = (pre_q == PS_LAST);
      boundary = tick && (cnt_q == CNT_LAST);
      duty_tgt = map_level(level_q);

      // Direction is decided from the live registers every clk, so a target
      // change mid-fade takes effect at the very next step.
      if (duty_tgt > duty_q)
         fade_dir = FADE_UP;
      else if (duty_tgt < duty_q)
         fade_dir = FADE_DOWN;
      else
         fade_dir = FADE_IDLE;

      pre_d = (pre_q == PS_LAST) ? '0 : pre_q + 1'b1;

      cnt_d = cnt_q;
      if (tick)
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

      fade_cnt_d = fade_cnt_q;
      duty_d     = duty_q;
      if (boundary) begin
         if (fade_cnt_q == FC_LAST) begin
            fade_cnt_d = '0;
            case (fade_dir)
               FADE_UP:   duty_d = step_up(duty_q, duty_tgt);
               FADE_DOWN: duty_d = step_down(duty_q, duty_tgt);
               default:   duty_d = duty_q;
            endcase
         end else begin
            fade_cnt_d = fade_cnt_q + 1'b1;
         end
      end

      level_d  = level_valid ? level_in : level_q;
      pwm_d    = enable && (cnt_q < duty_q);
      // First clk of count 0; the registered pulse lines up with pwm_out.
      pstart_d = (cnt_q == '0) && (pre_q == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q      <= '0;
         cnt_q      <= '0;
         fade_cnt_q <= '0;
         level_q    <= '0;
         duty_q     <= '0;
         pwm_q      <= 1'b0;
         pstart_q   <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         cnt_q      <= cnt_d;
         fade_cnt_q <= fade_cnt_d;
         level_q    <= level_d;
         duty_q     <= duty_d;
         pwm_q      <= pwm_d;
         pstart_q   <= pstart_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign duty_cur     = duty_q;
   assign fading       = (duty_q != duty_tgt);
   assign period_start = pstart_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: three parameterisations share one input stream
// and are compared every clk against a time-based reference model.
module tb_led_pwm_driver;

   localparam int PER = 255;

   logic       clk;
   logic       reset;
   logic [2:0] level_in;
   logic       level_valid;
   logic       enable;

   logic       o_pwm  [3];
   logic [7:0] o_duty [3];
   logic       o_fad  [3];
   logic       o_ps   [3];

   int p_pre  [3] = '{1, 3, 1};
   int p_step [3] = '{8, 40, 255};
   int p_fp   [3] = '{1, 2, 1};

   int n_total = 0;
   int n_bad   = 0;
   bit chk_on  = 0;

   led_pwm_driver #(.LEVEL_W(3), .PWM_W(8), .PRESCALE(1), .FADE_STEP(8), .FADE_PERIODS(1)) u_a (
      .clk(clk), .reset(reset), .level_in(level_in), .level_valid(level_valid), .enable(enable),
      .pwm_out(o_pwm[0]), .duty_cur(o_duty[0]), .fading(o_fad[0]), .period_start(o_ps[0]));

   led_pwm_driver #(.LEVEL_W(3), .PWM_W(8), .PRESCALE(3), .FADE_STEP(40), .FADE_PERIODS(2)) u_b (
      .clk(clk), .reset(reset), .level_in(level_in), .level_valid(level_valid), .enable(enable),
      .pwm_out(o_pwm[1]), .duty_cur(o_duty[1]), .fading(o_fad[1]), .period_start(o_ps[1]));

   led_pwm_driver #(.LEVEL_W(3), .PWM_W(8), .PRESCALE(1), .FADE_STEP(255), .FADE_PERIODS(1)) u_c (
      .clk(clk), .reset(reset), .level_in(level_in), .level_valid(level_valid), .enable(enable),
      .pwm_out(o_pwm[2]), .duty_cur(o_duty[2]), .fading(o_fad[2]), .period_start(o_ps[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input int obs, input int want);
      n_total++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, want, $time);
      end
   endtask

   function automatic int map_tgt(input int lvl);
`ifdef LED_PWM_GAMMA_EN
      int g [8] = '{0, 4, 11, 25, 50, 90, 150, 255};
      return g[lvl];
`else
      // Three copies of the 3-bit level form 9 bits; keep the top 8.
      return (lvl * 64 + lvl * 8 + lvl) >> 1;
`endif
   endfunction

   // Reference model: everything is derived from e, the number of clk edges
   // since reset release, and the fade rule applied at each step edge.
   int e_cnt;
   int m_level;
   int m_duty [3];
   int x_pwm  [3];
   int x_ps   [3];
   int x_fad  [3];

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            e_cnt   = 0;
            m_level = 0;
            for (int k = 0; k < 3; k++) begin
               m_duty[k] = 0; x_pwm[k] = 0; x_ps[k] = 0; x_fad[k] = 0;
            end
         end else begin
            e_cnt++;
            for (int k = 0; k < 3; k++) begin
               int plen, tgt, cnt_before;
               plen       = p_pre[k] * PER;
               cnt_before = ((e_cnt - 1) / p_pre[k]) % PER;
               x_pwm[k]   = (enable && (cnt_before < m_duty[k])) ? 1 : 0;
               x_ps[k]    = (((e_cnt - 1) % plen) == 0) ? 1 : 0;
               if ((e_cnt % plen) == 0 && ((e_cnt / plen) % p_fp[k]) == 0) begin
                  tgt = map_tgt(m_level);
                  if (tgt > m_duty[k])
                     m_duty[k] = (m_duty[k] + p_step[k] > tgt) ? tgt : m_duty[k] + p_step[k];
                  else if (tgt < m_duty[k])
                     m_duty[k] = (m_duty[k] - p_step[k] < tgt) ? tgt : m_duty[k] - p_step[k];
               end
            end
            if (level_valid) m_level = int'(level_in);
            for (int k = 0; k < 3; k++)
               x_fad[k] = (m_duty[k] != map_tgt(m_level)) ? 1 : 0;
         end
      end
   end

   // Continuous comparison on the falling edge, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_on && !reset) begin
            for (int k = 0; k < 3; k++) begin
               check_val($sformatf("pwm%0d", k),  int'(o_pwm[k]),  x_pwm[k]);
               check_val($sformatf("duty%0d", k), int'(o_duty[k]), m_duty[k]);
               check_val($sformatf("fad%0d", k),  int'(o_fad[k]),  x_fad[k]);
               check_val($sformatf("ps%0d", k),   int'(o_ps[k]),   x_ps[k]);
            end
         end
      end
   end

   task automatic load_level(input int lvl);
      @(negedge clk);
      level_in    = 3'(lvl);
      level_valid = 1'b1;
      @(negedge clk);
      level_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      level_in    = 3'd0;
      level_valid = 1'b0;
      enable      = 1'b1;

      // Reset state while clocks run.
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("rst_pwm%0d", k),  int'(o_pwm[k]),  0);
         check_val($sformatf("rst_duty%0d", k), int'(o_duty[k]), 0);
         check_val($sformatf("rst_fad%0d", k),  int'(o_fad[k]),  0);
         check_val($sformatf("rst_ps%0d", k),   int'(o_ps[k]),   0);
      end
      @(negedge clk);
      reset  = 1'b0;
      chk_on = 1'b1;

      // Fade up to level 4 (0x92 without gamma) over 20 periods.
      load_level(4);
      repeat (20 * PER) @(negedge clk);
      check_val("fade_up_duty_a", int'(o_duty[0]), map_tgt(4));
      check_val("fade_up_fad_a",  int'(o_fad[0]), 0);

      // Reverse toward zero mid-fade, then back up.
      load_level(0);
      repeat (10 * PER + 17) @(negedge clk);
      load_level(7);
      repeat (3 * PER) @(negedge clk);

      // Randomized level updates, bursts and enable gating.
      for (int it = 0; it < 40; it++) begin
         int n_upd;
         repeat ($urandom_range(1500, 50)) @(negedge clk);
         enable = ($urandom_range(3, 0) != 0);
         n_upd  = $urandom_range(3, 1);
         for (int u = 0; u < n_upd; u++) begin
            level_in    = 3'($urandom_range(7, 0));
            level_valid = 1'b1;
            @(negedge clk);
         end
         level_valid = 1'b0;
      end

      // Drive to full brightness, then reset while the output is high.
      enable = 1'b1;
      load_level(7);
      for (int i = 0; i < 10000 && x_pwm[0] == 0; i++) @(negedge clk);
      check_val("pre_rst_pwm_a", int'(o_pwm[0]), 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_val("async_rst_pwm_a", int'(o_pwm[0]), 0);
      check_val("async_rst_duty_a", int'(o_duty[0]), 0);
      check_val("async_rst_fad_a", int'(o_fad[0]), 0);
      check_val("async_rst_pwm_c", int'(o_pwm[2]), 0);
      repeat (3) @(negedge clk);
      check_val("held_rst_duty_b", int'(o_duty[1]), 0);
      reset = 1'b0;

      load_level(3);
      repeat (4 * PER) @(negedge clk);
      check_val("post_rst_duty_c", int'(o_duty[2]), map_tgt(3));

      chk_on = 1'b0;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream stage of the LED brightness controller. Consumes its brightness level (LEVEL_W bits) and drives the physical LED pin with a PWM waveform.
- A new level is latched as a target. The active duty cycle then fades toward it in fixed steps.
- Duty changes only at PWM period boundaries, so the output never glitches.

Parameters:
- LEVEL_W, 3, width of the brightness level input.
- PWM_W, 8, PWM counter/duty width. Period = 2^PWM_W-1 ticks.
- PRESCALE, 1, clk cycles per PWM tick (>=1).
- FADE_STEP, 8, maximum duty change per fade step (1..2^PWM_W-1).
- FADE_PERIODS, 1, PWM periods between fade steps (>=1).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, reset, asynchronous, active-high.
- level_in, input, LEVEL_W, brightness level from the upstream controller.
- level_valid, input, 1, level_in is latched into target when high on a clk edge.
- enable, input, 1, output gate. Low forces pwm_out low.
- pwm_out, output, 1, registered PWM drive to the LED.
- duty_cur, output, PWM_W, duty value active in the current period.
- fading, output, 1, high while duty_cur != duty_tgt.
- period_start, output, 1, one-clk pulse in the clk where PWM count 0 is first driven on pwm_out.

Behaviour:
- Reset (async, immediate):
  - prescaler=0, cnt=0, fade_cnt=0, target level=0, duty_cur=0.
  - pwm_out=0, period_start=0, fading=0.
  - A reset asserted mid-period drops pwm_out immediately.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick is high when the prescaler = PRESCALE-1, or always when PRESCALE=1.
- PWM counter cnt:
  - Advances on tick through 0..2^PWM_W-2, then wraps to 0.
- Output:
  - pwm_out <= enable && (cnt < duty_cur), registered, one clk latency.
  - duty_cur=0 gives constant low. duty_cur=2^PWM_W-1 gives constant high.
- Target mapping:
  - duty_tgt = level_reg bit-replicated MSB-first, truncated to PWM_W.
  - Example, 3->8 bits: 7 -> 0xFF, 4 -> 0x92, 1 -> 0x24, 0 -> 0x00.
- Fade state machine (IDLE, UP, DOWN), evaluated only at the period boundary (tick && cnt wraps to 0):
  - fade_cnt counts periods. A step occurs when fade_cnt = FADE_PERIODS-1, and fade_cnt then resets to 0.
  - On a step:
    - UP: duty_cur <= min(duty_cur+FADE_STEP, duty_tgt).
    - DOWN: duty_cur <= max(duty_cur-FADE_STEP, duty_tgt).
    - IDLE: duty_cur is unchanged.
  - Arithmetic uses PWM_W+1 bits, so the result never wraps.
  - State decision: duty_tgt > duty_cur -> UP; < -> DOWN; == -> IDLE.
  - The decision is re-evaluated every clk, so a target change mid-fade reverses direction at the next step.
- fading = (duty_cur != duty_tgt), combinational from registers.
- level_valid: an update is accepted on any clk. Only the last value before a step is used.
- enable low:
  - Only pwm_out is gated.
  - Counters and fade keep running.
  - Re-enable resumes on the current cnt with no restart.
- period_start: registered, aligned with pwm_out for cnt=0.
  - Asserts even when enable is low.

Optional Feature:
- Macro LED_PWM_GAMMA_EN.
- Defined:
  - duty_tgt comes from a fixed gamma table indexed by level_reg: 0,4,11,25,50,90,150,255.
  - Legal only with LEVEL_W=3, PWM_W=8. Any other combination is an elaboration error via a generate-time check.
- Undefined: bit-replication mapping as above. No table logic is present.

Test Plan:
- Reset behaviour: reset while pwm_out=1 mid-period -> pwm_out=0 in the same time step. duty_cur=0, fading=0 until release.
- Instant full on: FADE_STEP=255, load level 7 -> duty_cur=255 at the next boundary. pwm_out stays 1 for 3 full periods (765 clks). fading=0.
- Fade up: defaults, load level 4 -> duty_tgt=0x92.
  - duty_cur steps 8,16,...,144, then 146 on the 19th boundary, and fading falls.
  - pwm_out is high for 146 of 255 clks per period.
- Reversal mid-fade: load level 0 when duty_cur=64 -> next steps 56,48,...,0. No step ever exceeds 8. Final pwm_out is constant 0.
- Enable gating: enable=0 for 2 periods during a fade -> pwm_out=0 throughout. duty_cur still advances by 16. period_start keeps pulsing every 255 clks.
- Prescale: PRESCALE=3 -> period_start pulses every 765 clks. duty 0x92 gives a high time of 438 clks.
- Gamma build: with LED_PWM_GAMMA_EN and FADE_STEP=255, level 3 -> duty_cur=25 and high time 25 clks/period. level 7 -> 255.
